ep6_download_control: RTL and testbench
=======================================

EP6_DOWNLOAD_CONTROL -- requirements
Module: ep6_download_control

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of 256-bit entries in the output buffer (power of 2, 2..16).
REQ-002 SHALL have parameter AFULL_LVL, default 3, meaning the usedw level at or above which downfifo_AlmostFull asserts.
REQ-003 SHALL have port rdclk  input  1  meaning the single 100 MHz USB-side clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-005 SHALL have port usb_data_in  input  32  meaning a word read from the USB slave FIFO.
REQ-006 SHALL have port wrreq  input  1  meaning usb_data_in is valid this cycle.
REQ-007 SHALL have port pktend  input  1  meaning, when high with wrreq, that the word is the last of the USB packet.
REQ-008 SHALL have port rdreq  input  1  meaning the downstream consumer pops the head entry.
REQ-009 SHALL have port downfifo_dataout  output  256  meaning the head entry (first-word-fall-through).
REQ-010 SHALL have port downfifo_last  output  1  meaning the head entry closed a USB packet.
REQ-011 SHALL have port downfifo_empty  output  1  meaning no entry is held.
REQ-012 SHALL have port downfifo_full  output  1  meaning usedw == DEPTH.
REQ-013 SHALL have port downfifo_AlmostFull  output  1  meaning usedw >= AFULL_LVL; the host-read side stops issuing wrreq.
REQ-014 SHALL have port downfifo_usedw  output  $clog2(DEPTH)+1  meaning committed entries, 0..DEPTH.
REQ-015 SHALL have port pack_lane  output  3  meaning the lane index the next accepted word fills.
REQ-016 SHALL have port overflow_err  output  1  meaning a sticky flag set when a commit hits a full buffer.

Function
REQ-017 SHALL pack words little-endian: lane k occupies bits [32k+31:32k], and lane 0 is the first word of the entry.
REQ-018 SHALL, on wrreq, write usb_data_in into lane pack_lane of the assembly register and increment pack_lane (mod 8).
REQ-019 SHALL commit the assembly on the accepting cycle when pack_lane == 7 or pktend == 1; lanes above the current lane are zero-filled, last = pktend, and pack_lane returns to 0.
REQ-020 SHALL keep the assembly register free of stale data: lanes not written since the last commit read as zero.
REQ-021 SHALL make a committed entry visible on downfifo_dataout, with downfifo_empty low, on the cycle after the commit when the buffer was empty (latency 1).
REQ-022 SHALL pop on rdreq && !downfifo_empty; rdreq while empty SHALL be ignored with no pointer or count change.
REQ-023 SHALL, on a simultaneous commit and pop, write and pop the buffer with usedw unchanged, including when full.
REQ-024 SHALL, on a commit while full without a pop, drop the entry, leave the buffer unchanged, set overflow_err, and reset pack_lane to 0.
REQ-025 SHALL register downfifo_usedw, downfifo_full, downfifo_empty and downfifo_AlmostFull so they reflect the state after the current edge.
REQ-026 SHALL wrap buffer pointers modulo DEPTH with no gap or duplicate.

Reset
REQ-027 SHALL, on reset, set downfifo_usedw=0, downfifo_empty=1, downfifo_full=0, downfifo_AlmostFull=0, pack_lane=0, overflow_err=0, downfifo_last=0, downfifo_dataout=0, and discard any partial assembly.
REQ-028 SHALL give reset priority over wrreq and rdreq in the same cycle; overflow_err SHALL clear only on reset.

Structure
REQ-029 SHALL place LANES=8, WORD_W=32, ENTRY_W=256 and the entry struct {data, last} in shared package ep6_download_pkg.
REQ-030 SHALL implement the storage and pointers as the single sub-module ep6_pack_buffer (synchronous FWFT, DEPTH entries); the lane packer stays in the top level.

Verification
REQ-031 SHALL check that 8 words 0x00000001..0x00000008 on consecutive cycles give one entry with lane0=0x1 and lane7=0x8, last=0, and empty low one cycle after word 8.
REQ-032 SHALL check that 3 words 0xA,0xB,0xC with pktend on 0xC give one entry with lanes 0..2 = A,B,C, lanes 3..7 = 0, and last=1.
REQ-033 SHALL check that 32 words with rdreq=0 give full=1, usedw=4, and AlmostFull=1 from usedw=3, and that a 33rd..40th word sets overflow_err without corrupting the 4 held entries.
REQ-034 SHALL check that, with the buffer full, a commit and rdreq in the same cycle keep usedw=4 and data order is preserved.
REQ-035 SHALL check that reset asserted after 5 words, followed by 8 new words, yields exactly one entry containing only the new words.
REQ-036 SHALL check that rdreq while empty leaves usedw=0 and empty=1.

Source files
------------

// File: rtl/ep6_download_pkg.sv
// Shared widths and the buffered entry type for the EP6 download path.
// 32-bit USB words are gathered into 256-bit entries, lane 0 first.
package ep6_download_pkg;

  localparam int LANES   = 8;
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = LANES * WORD_W;
  localparam int LANE_W  = $clog2(LANES);

  typedef logic [LANE_W-1:0] lane_t;

  typedef struct packed {
    logic [ENTRY_W-1:0] data;
    logic               last;
  } entry_t;

  // Returns acc with one 32-bit lane replaced by word (little-endian lanes).
  function automatic logic [ENTRY_W-1:0] lane_insert(
    input logic [ENTRY_W-1:0] acc,
    input lane_t              lane,
    input logic [WORD_W-1:0]  word
  );
    logic [ENTRY_W-1:0] r;
    r = acc;
    r[int'(lane)*WORD_W +: WORD_W] = word;
    return r;
  endfunction

endpackage

// File: rtl/ep6_pack_buffer.sv
// Synchronous first-word-fall-through store of packed entries.
// Level flags are registered from the next count so they track the current edge.
module ep6_pack_buffer
  import ep6_download_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  entry_t                   wr_entry,
  input  logic                     rd_en,
  output entry_t                   rd_entry,
  output logic                     empty,
  output logic                     full,
  output logic                     afull,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             empty_q;
  logic             full_q;
  logic             afull_q;
  logic             push;
  logic             pop;

  // A write into a full buffer is only legal when the head leaves on the same edge.
  assign pop  = rd_en && !empty_q;
  assign push = wr_en && (!full_q || pop);
  assign drop = wr_en && full_q && !pop;

  always_comb begin
    count_next = count_q;
    case ({push, pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == CNT_W'(DEPTH));
      afull_q <= (count_next >= CNT_W'(AFULL_LVL));
    end
  end

  // Storage is not reset; the output gate below hides stale slots.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= wr_entry;
  end

  assign rd_entry = empty_q ? '0 : mem[rd_ptr];
  assign empty    = empty_q;
  assign full     = full_q;
  assign afull    = afull_q;
  assign usedw    = count_q;

endmodule

// File: rtl/ep6_download_control.sv
// EP6 download path: packs 32-bit USB words into 256-bit entries and buffers them.
// wrreq is a valid with no ready (the host must honor AlmostFull); rdreq pops only when !downfifo_empty.
module ep6_download_control
  import ep6_download_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                   rdclk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      usb_data_in,
  input  logic                   wrreq,
  input  logic                   pktend,
  input  logic                   rdreq,
  output logic [ENTRY_W-1:0]     downfifo_dataout,
  output logic                   downfifo_last,
  output logic                   downfifo_empty,
  output logic                   downfifo_full,
  output logic                   downfifo_AlmostFull,
  output logic [$clog2(DEPTH):0] downfifo_usedw,
  output logic [2:0]             pack_lane,
  output logic                   overflow_err
);

  logic [ENTRY_W-1:0] acc_q;
  logic [ENTRY_W-1:0] acc_next;
  lane_t              lane_q;
  logic               commit;
  entry_t             commit_entry;
  entry_t             head_entry;
  logic               drop;
  logic               overflow_q;

  // Untouched lanes are already zero because the accumulator clears on every commit.
  always_comb begin
    acc_next          = lane_insert(acc_q, lane_q, usb_data_in);
    commit            = wrreq && ((lane_q == lane_t'(LANES - 1)) || pktend);
    commit_entry.data = acc_next;
    commit_entry.last = pktend;
  end

  always_ff @(posedge rdclk) begin
    if (reset) begin
      acc_q      <= '0;
      lane_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wrreq) begin
        if (commit) begin
          acc_q  <= '0;
          lane_q <= '0;
        end else begin
          acc_q  <= acc_next;
          lane_q <= lane_q + lane_t'(1);
        end
      end
      if (commit && drop) overflow_q <= 1'b1;
    end
  end

  ep6_pack_buffer #(
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_buffer (
    .clk      (rdclk),
    .reset    (reset),
    .wr_en    (commit),
    .wr_entry (commit_entry),
    .rd_en    (rdreq),
    .rd_entry (head_entry),
    .empty    (downfifo_empty),
    .full     (downfifo_full),
    .afull    (downfifo_AlmostFull),
    .drop     (drop),
    .usedw    (downfifo_usedw)
  );

  assign downfifo_dataout = head_entry.data;
  assign downfifo_last    = head_entry.last;
  assign pack_lane        = lane_q;
  assign overflow_err     = overflow_q;

endmodule

// File: tb/tb_ep6_download_control.sv
// Bench for ep6_download_control: status vector table plus directed multi-cycle sequences.
module tb_ep6_download_control;
  import ep6_download_pkg::*;

  localparam int DEPTH     = 4;
  localparam int AFULL_LVL = 3;

  logic               rdclk = 1'b0;
  logic               reset;
  logic [WORD_W-1:0]  usb_data_in;
  logic               wrreq;
  logic               pktend;
  logic               rdreq;
  logic [ENTRY_W-1:0] downfifo_dataout;
  logic               downfifo_last;
  logic               downfifo_empty;
  logic               downfifo_full;
  logic               downfifo_AlmostFull;
  logic [2:0]         downfifo_usedw;
  logic [2:0]         pack_lane;
  logic               overflow_err;

  int checks = 0;
  int errors = 0;
  logic [ENTRY_W:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        pe;
    logic [31:0] d;
    logic        rd;
    logic [2:0]  usedw;
    logic        empty;
    logic        full;
    logic        afull;
    logic [2:0]  lane;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  ep6_download_control #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
    .rdclk               (rdclk),
    .reset               (reset),
    .usb_data_in         (usb_data_in),
    .wrreq               (wrreq),
    .pktend              (pktend),
    .rdreq               (rdreq),
    .downfifo_dataout    (downfifo_dataout),
    .downfifo_last       (downfifo_last),
    .downfifo_empty      (downfifo_empty),
    .downfifo_full       (downfifo_full),
    .downfifo_AlmostFull (downfifo_AlmostFull),
    .downfifo_usedw      (downfifo_usedw),
    .pack_lane           (pack_lane),
    .overflow_err        (overflow_err)
  );

  always #5 rdclk = ~rdclk;

  function automatic vec_t mk(logic wr, logic pe, logic [31:0] d, logic rd,
                              logic [2:0] uw, logic em, logic fu, logic af,
                              logic [2:0] ln, logic ov);
    vec_t v;
    v.wr = wr; v.pe = pe; v.d = d; v.rd = rd;
    v.usedw = uw; v.empty = em; v.full = fu; v.afull = af; v.lane = ln; v.ovf = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [ENTRY_W:0] act, input logic [ENTRY_W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] uw, input logic em,
                              input logic fu, input logic af, input logic [2:0] ln, input logic ov);
    check({tag, ".usedw"}, (ENTRY_W+1)'(downfifo_usedw), (ENTRY_W+1)'(uw));
    check({tag, ".empty"}, (ENTRY_W+1)'(downfifo_empty), (ENTRY_W+1)'(em));
    check({tag, ".full"},  (ENTRY_W+1)'(downfifo_full),  (ENTRY_W+1)'(fu));
    check({tag, ".afull"}, (ENTRY_W+1)'(downfifo_AlmostFull), (ENTRY_W+1)'(af));
    check({tag, ".lane"},  (ENTRY_W+1)'(pack_lane),      (ENTRY_W+1)'(ln));
    check({tag, ".ovf"},   (ENTRY_W+1)'(overflow_err),   (ENTRY_W+1)'(ov));
  endtask

  task automatic check_head(input string tag);
    logic [ENTRY_W:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty, nothing expected at head", tag);
    end else begin
      exp = exp_q.pop_front();
      check({tag, ".head"}, {downfifo_last, downfifo_dataout}, exp);
    end
  endtask

  task automatic step(input logic wr, input logic pe, input logic [31:0] d, input logic rd);
    wrreq = wr; pktend = pe; usb_data_in = d; rdreq = rd;
    @(posedge rdclk);
    #1;
    wrreq = 1'b0; pktend = 1'b0; usb_data_in = '0; rdreq = 1'b0;
  endtask

  task automatic do_reset(input logic with_traffic);
    reset = 1'b1;
    wrreq = with_traffic; pktend = 1'b0; rdreq = with_traffic; usb_data_in = 32'hBAD0_BAD0;
    repeat (2) @(posedge rdclk);
    #1;
    reset = 1'b0; wrreq = 1'b0; rdreq = 1'b0; usb_data_in = '0;
  endtask

  function automatic logic [31:0] seq_word(int n, int k);
    return 32'h1000_0000 + 32'(n * 16 + k);
  endfunction

  initial begin
    logic [ENTRY_W:0] ents [6];
    logic             prev_empty;
    reset = 1'b0; wrreq = 1'b0; pktend = 1'b0; rdreq = 1'b0; usb_data_in = '0;

    do_reset(1'b0);
    check_status("reset", 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    check("reset.head", {downfifo_last, downfifo_dataout}, '0);

    // Table: status after each cycle; heads are checked whenever a pop should occur.
    vecs.push_back(mk(0, 0, 32'h0, 1, 3'd0, 1, 0, 0, 3'd0, 0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(mk(1, 0, 32'(k), 0, 3'd0, 1, 0, 0, 3'(k), 0));
    vecs.push_back(mk(1, 0, 32'h8, 0, 3'd1, 0, 0, 0, 3'd0, 0));
    vecs.push_back(mk(1, 0, 32'hA, 0, 3'd1, 0, 0, 0, 3'd1, 0));
    vecs.push_back(mk(1, 0, 32'hB, 0, 3'd1, 0, 0, 0, 3'd2, 0));
    vecs.push_back(mk(1, 1, 32'hC, 0, 3'd2, 0, 0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3'd1, 0, 0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3'd0, 1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3'd0, 1, 0, 0, 3'd0, 0));
    vecs.push_back(mk(1, 1, 32'h77, 0, 3'd1, 0, 0, 0, 3'd0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 1, 3'd0, 1, 0, 0, 3'd0, 0));
    exp_q.push_back({1'b0, 32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
    exp_q.push_back({1'b1, 160'h0, 32'hC, 32'hB, 32'hA});
    exp_q.push_back({1'b1, 224'h0, 32'h77});

    prev_empty = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rd && !prev_empty) check_head($sformatf("vec%0d", i));
      step(vecs[i].wr, vecs[i].pe, vecs[i].d, vecs[i].rd);
      check_status($sformatf("vec%0d", i), vecs[i].usedw, vecs[i].empty, vecs[i].full,
                   vecs[i].afull, vecs[i].lane, vecs[i].ovf);
      prev_empty = vecs[i].empty;
    end

    // Fill to full, then overflow with a fifth entry.
    for (int n = 0; n < 6; n++) begin
      ents[n] = '0;
      for (int k = 0; k < 8; k++) ents[n][k*32 +: 32] = seq_word(n, k);
    end
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 8; k++) step(1, 0, seq_word(n, k), 0);
      check_status($sformatf("fill%0d", n), 3'(n + 1), 1'b0, n == 3, n >= 2, 3'd0, 1'b0);
      exp_q.push_back(ents[n]);
    end
    for (int k = 0; k < 7; k++) step(1, 0, seq_word(4, k), 0);
    check_status("ovf_pre", 3'd4, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0);
    step(1, 0, seq_word(4, 7), 0);
    check_status("ovf_hit", 3'd4, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);

    // Commit and pop on the same edge while full.
    for (int k = 0; k < 7; k++) step(1, 0, seq_word(5, k), 0);
    check_head("fullrw");
    step(1, 0, seq_word(5, 7), 1);
    exp_q.push_back(ents[5]);
    check_status("fullrw", 3'd4, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      check_head($sformatf("drain%0d", n));
      step(0, 0, 32'h0, 1);
    end
    check_status("drained", 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step(0, 0, 32'h0, 1);
    check_status("empty_rd", 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);

    // Reset mid-assembly discards the partial entry; reset beats wrreq/rdreq.
    for (int k = 0; k < 5; k++) step(1, 0, 32'hDEAD_0000 + 32'(k), 0);
    check_status("partial", 3'd0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1);
    do_reset(1'b1);
    check_status("rst2", 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    for (int k = 0; k < 8; k++) step(1, 0, 32'h5000_0000 + 32'(k), 0);
    check_status("post_rst", 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    exp_q.push_back({1'b0, 32'h5000_0007, 32'h5000_0006, 32'h5000_0005, 32'h5000_0004,
                     32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000});
    check_head("post_rst");
    step(0, 0, 32'h0, 1);
    check_status("post_rst_pop", 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
